fetch_controller: RTL and testbench

- Sequences the combinational instruction memory: owns the PC and drives the byte address into the memory.
- Registers each returned 32-bit instruction toward decode over a valid/ready handshake.
- Handles branch/jump redirects, a halt-on-zero-word terminator and misaligned-target faults.
- Sits between the instruction memory and the decode stage of the RISC-V core.

---
 rtl/fetch_controller_pkg.sv | 15 +
 rtl/fetch_controller.sv | 103 ++++++++++
 tb/tb_fetch_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_controller_pkg;

    // Fetch sequencer states; FAULT is left only through reset.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetchState_t;

    localparam logic [31:0] INSTR_BYTES       = 32'd4;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, addresses the combinational
// instruction memory and presents each fetched word to decode over a
// valid/ready handshake, with redirect, halt-word and misalignment handling.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MEM_BYTES = 65536,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        fetchEnable,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic [31:0] imemAddress,
    input  logic [31:0] imemInstruction,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instrOut,
    output logic [31:0] instrPc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetchCount
);

    // MEM_BYTES is a power of two, so masking gives the modulo wrap and keeps
    // the PC bits above the memory size at zero.
    localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

    fetchState_t state, stateNext;
    logic [31:0] pc, pcNext;
    logic        instrValidNext;
    logic [31:0] instrOutNext;
    logic [31:0] instrPcNext;
    logic        captureSlot;
    logic        transfer;

    assign imemAddress = pc;
    assign halted      = (state == HALTED);
    assign fault       = (state == FAULT);
    assign transfer    = instrValid && instrReady;
    assign captureSlot = (state == RUN) && fetchEnable && (!instrValid || instrReady);

    // Next-state logic: redirect beats capture and halt detection; a consumed
    // output with no replacement drops valid so decode never sees it twice.
    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        instrValidNext = instrValid;
        instrOutNext   = instrOut;
        instrPcNext    = instrPc;
        if (transfer) begin
            instrValidNext = 1'b0;
        end
        if (state != FAULT && redirectValid) begin
            instrValidNext = 1'b0;
            if (redirectTarget[1:0] == 2'b00) begin
                pcNext    = redirectTarget & PC_MASK;
                stateNext = RUN;
            end else begin
                stateNext = FAULT;
            end
        end else if (captureSlot) begin
            if (imemInstruction == HALT_WORD) begin
                instrValidNext = 1'b0;
                stateNext      = HALTED;
            end else begin
                instrOutNext   = imemInstruction;
                instrPcNext    = pc;
                instrValidNext = 1'b1;
                pcNext         = (pc + INSTR_BYTES) & PC_MASK;
            end
        end
    end

    // State, PC and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= RUN;
            pc         <= RESET_PC & PC_MASK;
            instrValid <= 1'b0;
            instrOut   <= 32'd0;
            instrPc    <= 32'd0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            instrValid <= instrValidNext;
            instrOut   <= instrOutNext;
            instrPc    <= instrPcNext;
        end
    end

    // Handshake counter, one step per completed transfer in any state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fetchCount <= 32'd0;
        end else if (transfer) begin
            fetchCount <= fetchCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller with a scoreboard of expected
// {instrPc, instrOut} pairs compared on every handshake.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        fetchEnable;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [31:0] imemAddress;
    logic [31:0] imemInstruction;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        halted;
    logic        fault;
    logic [31:0] fetchCount;

    logic [31:0] mem [0:16383];
    logic [63:0] expectQ [$];
    int          checks   = 0;
    int          failures = 0;

    localparam logic [31:0] W0 = 32'h0010_0093;
    localparam logic [31:0] W1 = 32'h0020_0113;
    localparam logic [31:0] W2 = 32'h4011_11B3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_controller dut (
        .clk             (clk),
        .resetN          (resetN),
        .fetchEnable     (fetchEnable),
        .redirectValid   (redirectValid),
        .redirectTarget  (redirectTarget),
        .imemAddress     (imemAddress),
        .imemInstruction (imemInstruction),
        .instrValid      (instrValid),
        .instrReady      (instrReady),
        .instrOut        (instrOut),
        .instrPc         (instrPc),
        .halted          (halted),
        .fault           (fault),
        .fetchCount      (fetchCount)
    );

    always #5 clk = ~clk;

    assign imemInstruction = mem[imemAddress[15:2]];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Scoreboard: each handshake about to complete must match the oldest expectation.
    always @(negedge clk) begin
        if (resetN && instrValid && instrReady) begin
            if (expectQ.size() == 0) begin
                checkOutput("sbUnexpected", instrPc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = expectQ.pop_front();
                checkOutput("sbPc", instrPc, e[63:32]);
                checkOutput("sbInstr", instrOut, e[31:0]);
            end
        end
    end

    task automatic loadProgram();
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;
        mem[3] = 32'd0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        resetN         = 1'b0;
        fetchEnable    = 1'b0;
        instrReady     = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = 32'd0;
        expectQ.delete();
        repeat (2) stepCycle();
        resetN = 1'b1;
    endtask

    task automatic applyStimulus(input logic [31:0] target);
        redirectValid  = 1'b1;
        redirectTarget = target;
        stepCycle();
        redirectValid  = 1'b0;
    endtask

    task automatic waitHalt(input int maxCycles);
        for (int i = 0; i < maxCycles && !halted; i++) stepCycle();
        checkOutput("haltReached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        loadProgram();

        // Reset values
        resetN         = 1'b0;
        fetchEnable    = 1'b0;
        instrReady     = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = 32'd0;
        #2;
        checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
        checkOutput("rstInstr", instrOut, 32'd0);
        checkOutput("rstPc", instrPc, 32'd0);
        checkOutput("rstHalted", {31'd0, halted}, 32'd0);
        checkOutput("rstFault", {31'd0, fault}, 32'd0);
        checkOutput("rstCount", fetchCount, 32'd0);
        checkOutput("rstAddr", imemAddress, 32'd0);

        // Straight-line program runs to the halt word
        applyReset();
        expectQ.push_back({32'd0, W0});
        expectQ.push_back({32'd4, W1});
        expectQ.push_back({32'd8, W2});
        fetchEnable = 1'b1;
        instrReady  = 1'b1;
        waitHalt(20);
        checkOutput("haltAddr", imemAddress, 32'd12);
        checkOutput("haltCount", fetchCount, 32'd3);
        checkOutput("haltValid", {31'd0, instrValid}, 32'd0);
        checkOutput("sbEmpty1", expectQ.size(), 32'd0);

        // Backpressure after the first capture
        applyReset();
        expectQ.push_back({32'd0, W0});
        expectQ.push_back({32'd4, W1});
        expectQ.push_back({32'd8, W2});
        fetchEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("stallInstr", instrOut, W0);
            checkOutput("stallPc", instrPc, 32'd0);
            checkOutput("stallAddr", imemAddress, 32'd4);
        end
        instrReady = 1'b1;
        waitHalt(20);
        checkOutput("stallCount", fetchCount, 32'd3);
        checkOutput("sbEmpty2", expectQ.size(), 32'd0);

        // Redirect out of HALTED
        expectQ.push_back({32'd4, W1});
        expectQ.push_back({32'd8, W2});
        applyStimulus(32'd4);
        checkOutput("resumeHalted", {31'd0, halted}, 32'd0);
        checkOutput("resumeValid0", {31'd0, instrValid}, 32'd0);
        checkOutput("resumeAddr", imemAddress, 32'd4);
        stepCycle();
        checkOutput("resumeValid1", {31'd0, instrValid}, 32'd1);
        checkOutput("resumePc", instrPc, 32'd4);
        waitHalt(20);
        checkOutput("resumeHaltAddr", imemAddress, 32'd12);
        checkOutput("resumeCount", fetchCount, 32'd5);
        checkOutput("sbEmpty3", expectQ.size(), 32'd0);

        // Redirect flushes an output held under backpressure
        applyReset();
        expectQ.push_back({32'd0, W0});
        fetchEnable = 1'b1;
        instrReady  = 1'b1;
        stepCycle();
        stepCycle();
        instrReady = 1'b0;
        checkOutput("heldPc", instrPc, 32'd4);
        checkOutput("heldValid", {31'd0, instrValid}, 32'd1);
        applyStimulus(32'd8);
        instrReady = 1'b1;
        expectQ.push_back({32'd8, W2});
        checkOutput("flushValid", {31'd0, instrValid}, 32'd0);
        checkOutput("flushAddr", imemAddress, 32'd8);
        waitHalt(20);
        checkOutput("flushCount", fetchCount, 32'd2);
        checkOutput("sbEmpty4", expectQ.size(), 32'd0);

        // Misaligned redirect faults; only reset recovers
        applyStimulus(32'd6);
        checkOutput("faultSet", {31'd0, fault}, 32'd1);
        checkOutput("faultValid", {31'd0, instrValid}, 32'd0);
        checkOutput("faultAddr", imemAddress, 32'd12);
        applyStimulus(32'd0);
        repeat (2) stepCycle();
        checkOutput("faultSticky", {31'd0, fault}, 32'd1);
        checkOutput("faultIgnore", imemAddress, 32'd12);
        checkOutput("faultValid2", {31'd0, instrValid}, 32'd0);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("asyncFault", {31'd0, fault}, 32'd0);
        checkOutput("asyncCount", fetchCount, 32'd0);
        checkOutput("asyncAddr", imemAddress, 32'd0);
        stepCycle();
        resetN = 1'b1;
        expectQ.push_back({32'd0, W0});
        expectQ.push_back({32'd4, W1});
        expectQ.push_back({32'd8, W2});
        waitHalt(20);
        checkOutput("restartCount", fetchCount, 32'd3);
        checkOutput("sbEmpty5", expectQ.size(), 32'd0);

        // PC wraps from the top of memory to zero
        mem[16383] = NOP;
        mem[0]     = NOP;
        mem[1]     = 32'd0;
        expectQ.push_back({32'h0000_FFFC, NOP});
        expectQ.push_back({32'h0000_0000, NOP});
        applyStimulus(32'h0000_FFFC);
        waitHalt(20);
        checkOutput("wrapHaltAddr", imemAddress, 32'd4);
        checkOutput("wrapCount", fetchCount, 32'd5);
        checkOutput("sbEmpty6", expectQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
